// File: rtl/axi_lite_reg_bank_if.sv
// rtl/axi_lite_reg_bank_if.sv - AXI4-Lite write/read channel bundle for the register bank
interface axi_lite_reg_bank_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// rtl/axi_lite_reg_bank.sv - AXI4-Lite bank of R/W control registers and read-only status words
module axi_lite_reg_bank #(
    parameter int          NUM_CTRL = 4,
    parameter int          NUM_STAT = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    axi_lite_reg_bank_if.slave       s_axi,
    output logic [32*NUM_CTRL-1:0]   ctrl_out,
    output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
    input  logic [32*NUM_STAT-1:0]   stat_in,
    output logic [NUM_STAT-1:0]      stat_rd_pulse
);
    localparam int          IDX_W       = ADDR_W - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [31:0]       ctrl_q [NUM_CTRL];
    logic [31:0]       ctrl_d [NUM_CTRL];

    r_state_t          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [NUM_STAT-1:0] spulse_q, spulse_d;

    logic [31:0]       widx_u, ridx_u;
    logic              unused_addr_bits;

    assign widx_u           = 32'(widx_q);
    assign ridx_u           = 32'(s_axi.araddr[ADDR_W-1:2]);
    assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Write path: AW and W are captured independently, then committed together.
    always_comb begin
        w_state_d     = w_state_q;
        aw_held_d     = aw_held_q;
        w_held_d      = w_held_q;
        widx_d        = widx_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        ctrl_d        = ctrl_q;
        ctrl_wr_pulse = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    widx_d    = s_axi.awaddr[ADDR_W-1:2];
                end
                if (s_axi.wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.wdata;
                    wstrb_d  = s_axi.wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = RESP_SLVERR;
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (widx_u == i) begin
                        bresp_d          = RESP_OKAY;
                        ctrl_wr_pulse[i] = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) begin
                                ctrl_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read path: the status pulse lives only for the first rvalid cycle.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        spulse_d  = '0;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                    rdata_d   = 32'hDEAD_BEEF;
                    rresp_d   = RESP_SLVERR;
                    for (int i = 0; i < NUM_CTRL; i++) begin
                        if (ridx_u == i) begin
                            rdata_d = ctrl_q[i];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int j = 0; j < NUM_STAT; j++) begin
                        if (ridx_u == NUM_CTRL + j) begin
                            rdata_d     = stat_in[32*j +: 32];
                            rresp_d     = RESP_OKAY;
                            spulse_d[j] = 1'b1;
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_q[i] <= CTRL_RST;
            end
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            spulse_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ctrl_q    <= ctrl_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            spulse_q  <= spulse_d;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_out[32*g +: 32] = ctrl_q[g];
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign stat_rd_pulse = spulse_q;
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb/tb_axi_lite_reg_bank.sv - self-checking bench for axi_lite_reg_bank
module tb_axi_lite_reg_bank;
    localparam int NC = 4;
    localparam int NS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] ctrl_out;
    logic [3:0]   ctrl_wr_pulse;
    logic [127:0] stat_in;
    logic [3:0]   stat_rd_pulse;

    always #5 clk = ~clk;

    axi_lite_reg_bank_if #(.ADDR_W(8)) bus ();

    axi_lite_reg_bank #(
        .NUM_CTRL(NC), .NUM_STAT(NS), .ADDR_W(8), .CTRL_RST(32'h0)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (bus),
        .ctrl_out      (ctrl_out),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .stat_in       (stat_in),
        .stat_rd_pulse (stat_rd_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_ctrl [NC];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          awd;
        int          wd;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [7:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic logic [127:0] m_pack();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    function automatic logic [1:0] m_bresp(input logic [7:0] a);
        return (widx(a) < NC) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [7:0] a);
        int i = widx(a);
        if (i < NC) return m_ctrl[i];
        if (i < NC + NS) return stat_in[32*(i-NC) +: 32];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [1:0] m_rresp(input logic [7:0] a);
        return (widx(a) < NC + NS) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int i = widx(a);
        if (i < NC) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_ctrl[i][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NC; i++) m_ctrl[i] = 32'h0;
    endtask

    // Leaves the bench at #1 after the edge that entered the commit cycle.
    task automatic wr_start(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        int i = widx(a);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.awvalid = !aw_done && (cyc >= awd);
            bus.wvalid  = !w_done && (cyc >= wd);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        chk("wr_pulse", ctrl_wr_pulse, (i < NC) ? 4'(1 << i) : 4'b0);
    endtask

    task automatic wr_finish(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_b);
        @(posedge clk); #1;
        m_write(a, d, s);
        chk("wr_bvalid", bus.bvalid, 1'b1);
        chk("wr_bresp", bus.bresp, exp_b);
        chk("wr_ctrl_out", ctrl_out, m_pack());
        chk("wr_pulse_off", ctrl_wr_pulse, 4'b0);
        bus.bready = 1;
        @(posedge clk); #1;
        bus.bready = 0;
        chk("wr_bvalid_off", bus.bvalid, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input logic [1:0] exp_b);
        wr_start(a, d, s, awd, wd);
        wr_finish(a, d, s, exp_b);
    endtask

    task automatic rd(input logic [7:0] a, input int hold, input logic [31:0] exp_d,
                      input logic [1:0] exp_r, input string tag);
        int cyc = 0;
        int i = widx(a);
        logic [3:0] exp_p;
        exp_p = (i >= NC && i < NC + NS) ? 4'(1 << (i - NC)) : 4'b0;
        bus.araddr = a; bus.arvalid = 1;
        while (!bus.arready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_arready"}, bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 0;
        chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
        chk({tag, "_rdata"}, bus.rdata, exp_d);
        chk({tag, "_rresp"}, bus.rresp, exp_r);
        chk({tag, "_spulse"}, stat_rd_pulse, exp_p);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, bus.rvalid, 1'b1);
            chk({tag, "_hold_data"}, bus.rdata, exp_d);
            chk({tag, "_hold_resp"}, bus.rresp, exp_r);
            chk({tag, "_hold_spulse"}, stat_rd_pulse, 4'b0);
        end
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        chk({tag, "_rvalid_off"}, bus.rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra;
        logic [31:0] rdv;
        logic [3:0]  rs;

        vecs[0] = '{8'h04, 32'hA5A5_1234, 4'hF, 0, 0, 2'b00, 32'hA5A5_1234, 2'b00};
        vecs[1] = '{8'h00, 32'h1111_1111, 4'hF, 0, 0, 2'b00, 32'h1111_1111, 2'b00};
        vecs[2] = '{8'h00, 32'h0000_BB00, 4'h2, 3, 0, 2'b00, 32'h1111_BB11, 2'b00};
        vecs[3] = '{8'h0B, 32'h1234_5678, 4'h5, 1, 2, 2'b00, 32'h0034_0078, 2'b00};
        vecs[4] = '{8'h0C, 32'hFFFF_FFFF, 4'h0, 0, 1, 2'b00, 32'h0000_0000, 2'b00};
        vecs[5] = '{8'h14, 32'h1234_5678, 4'hF, 0, 0, 2'b10, 32'hCAFE_0001, 2'b00};
        vecs[6] = '{8'h3C, 32'h0000_0001, 4'hF, 2, 2, 2'b10, 32'hDEAD_BEEF, 2'b10};
        vecs[7] = '{8'h1C, 32'h0000_0001, 4'hF, 0, 0, 2'b10, 32'h5A00_0003, 2'b00};

        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        stat_in = {32'h5A00_0003, 32'h5A00_0002, 32'hCAFE_0001, 32'h5A00_0000};
        m_reset();

        #12;
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_ctrl_out", ctrl_out, 128'h0);
        chk("rst_pulses", {ctrl_wr_pulse, stat_rd_pulse}, 8'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("idle_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

        for (int v = 0; v < 8; v++) begin
            do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].awd, vecs[v].wd,
                     vecs[v].exp_bresp);
            rd(vecs[v].addr, 0, vecs[v].exp_rd, vecs[v].exp_rresp, "tbl");
        end

        rd(8'h3C, 5, 32'hDEAD_BEEF, 2'b10, "unmapped_hold");

        do_write(8'h00, 32'h1, 4'hF, 0, 0, 2'b00);
        wr_start(8'h00, 32'h2, 4'hF, 0, 0);
        bus.araddr = 8'h00; bus.arvalid = 1;
        @(posedge clk); #1;
        bus.arvalid = 0;
        chk("race_rvalid", bus.rvalid, 1'b1);
        chk("race_rdata_old", bus.rdata, 32'h1);
        chk("race_bvalid", bus.bvalid, 1'b1);
        m_write(8'h00, 32'h2, 4'hF);
        bus.rready = 1; bus.bready = 1;
        @(posedge clk); #1;
        bus.rready = 0; bus.bready = 0;
        chk("race_done", {bus.rvalid, bus.bvalid}, 2'b00);
        rd(8'h00, 0, 32'h2, 2'b00, "race_new");

        for (int n = 0; n < 60; n++) begin
            ra  = {2'b00, 4'($urandom_range(0, 11)), 2'($urandom)};
            rdv = $urandom;
            rs  = 4'($urandom);
            stat_in[32*$urandom_range(0, NS-1) +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(ra, rdv, rs, $urandom_range(0, 3), $urandom_range(0, 3), m_bresp(ra));
            else
                rd(ra, $urandom_range(0, 2), m_rdata(ra), m_rresp(ra), "rnd");
        end

        wr_start(8'h08, 32'hBEEF_0000, 4'hF, 0, 0);
        @(posedge clk); #1;
        chk("rstmid_bvalid", bus.bvalid, 1'b1);
        #2 rst_n = 0;
        #1;
        m_reset();
        chk("rstmid_bvalid_drop", bus.bvalid, 1'b0);
        chk("rstmid_ctrl_out", ctrl_out, m_pack());
        chk("rstmid_awready", bus.awready, 1'b0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        do_write(8'h08, 32'h0000_CAFE, 4'hF, 1, 0, 2'b00);
        rd(8'h08, 0, 32'h0000_CAFE, 2'b00, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
